// File: rtl/rc_ring_out_arb.sv
// Ring-output arbiter: picks ring pass-through, C2F request or F2C response each cycle,
// registers the winner as the Q502H ring output and tracks local starvation.
package rc_ring_out_arb_pkg;
    typedef logic [3:0] t_opcode;
    typedef enum logic [1:0] {
        NO_WINNER    = 2'd0,
        BYPASS       = 2'd1,
        C2F_REQUEST  = 2'd2,
        F2C_RESPONSE = 2'd3
    } t_winner;
endpackage

module rc_ring_out_arb
    import rc_ring_out_arb_pkg::*;
#(
    parameter int STARVE_TH = 16,
    parameter int STARVE_W  = 8
) (
    input  logic                QClk,
    input  logic                RstQnnnH,

    input  logic                RingPassValidQ501H,
    input  logic [9:0]          RingPassRequestorQ501H,
    input  t_opcode             RingPassOpcodeQ501H,
    input  logic [31:0]         RingPassAddressQ501H,
    input  logic [31:0]         RingPassDataQ501H,

    input  logic                C2F_ReqValidQ501H,
    input  logic [9:0]          C2F_ReqRequestorQ501H,
    input  t_opcode             C2F_ReqOpcodeQ501H,
    input  logic [31:0]         C2F_ReqAddressQ501H,
    input  logic [31:0]         C2F_ReqDataQ501H,

    input  logic                F2C_RspValidQ501H,
    input  logic [9:0]          F2C_RspRequestorQ501H,
    input  t_opcode             F2C_RspOpcodeQ501H,
    input  logic [31:0]         F2C_RspAddressQ501H,
    input  logic [31:0]         F2C_RspDataQ501H,

    output t_winner             SelRingReqOutQ501H,

    output logic                RingReqOutValidQ502H,
    output logic [9:0]          RingReqOutRequestorQ502H,
    output t_opcode             RingReqOutOpcodeQ502H,
    output logic [31:0]         RingReqOutAddressQ502H,
    output logic [31:0]         RingReqOutDataQ502H,

    output logic                LocalStarveQnnnH,
    output logic [STARVE_W-1:0] StarveCntQnnnH
);

    localparam logic [STARVE_W-1:0] StarveThr = STARVE_W'(STARVE_TH);
    localparam logic [STARVE_W-1:0] StarveMax = {STARVE_W{1'b1}};

    t_winner     winner;
    logic        lastLocalQnnnH;
    logic        lastLocalNxt;
    logic        localAny;
    logic [STARVE_W-1:0] starveCntNxt;

    logic        nxtValid;
    logic [9:0]  nxtRequestor;
    t_opcode     nxtOpcode;
    logic [31:0] nxtAddress;
    logic [31:0] nxtData;

    assign localAny           = C2F_ReqValidQ501H | F2C_RspValidQ501H;
    assign SelRingReqOutQ501H = winner;

    // Ring traffic cannot be back-pressured, so it always wins; locals share round-robin.
    always_comb begin
        winner = NO_WINNER;
        if (RingPassValidQ501H) begin
            winner = BYPASS;
        end else if (C2F_ReqValidQ501H && F2C_RspValidQ501H) begin
            winner = lastLocalQnnnH ? C2F_REQUEST : F2C_RESPONSE;
        end else if (C2F_ReqValidQ501H) begin
            winner = C2F_REQUEST;
        end else if (F2C_RspValidQ501H) begin
            winner = F2C_RESPONSE;
        end
    end

    always_comb begin
        nxtValid     = 1'b0;
        nxtRequestor = '0;
        nxtOpcode    = '0;
        nxtAddress   = '0;
        nxtData      = '0;
        lastLocalNxt = lastLocalQnnnH;
        case (winner)
            BYPASS: begin
                nxtValid     = 1'b1;
                nxtRequestor = RingPassRequestorQ501H;
                nxtOpcode    = RingPassOpcodeQ501H;
                nxtAddress   = RingPassAddressQ501H;
                nxtData      = RingPassDataQ501H;
            end
            C2F_REQUEST: begin
                nxtValid     = 1'b1;
                nxtRequestor = C2F_ReqRequestorQ501H;
                nxtOpcode    = C2F_ReqOpcodeQ501H;
                nxtAddress   = C2F_ReqAddressQ501H;
                nxtData      = C2F_ReqDataQ501H;
                lastLocalNxt = 1'b0;
            end
            F2C_RESPONSE: begin
                nxtValid     = 1'b1;
                nxtRequestor = F2C_RspRequestorQ501H;
                nxtOpcode    = F2C_RspOpcodeQ501H;
                nxtAddress   = F2C_RspAddressQ501H;
                nxtData      = F2C_RspDataQ501H;
                lastLocalNxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Count only cycles where local work is blocked by ring traffic; saturate, never wrap.
    always_comb begin
        starveCntNxt = '0;
        if (localAny && (winner == BYPASS)) begin
            starveCntNxt = (StarveCntQnnnH == StarveMax) ? StarveMax
                                                         : StarveCntQnnnH + STARVE_W'(1);
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            RingReqOutValidQ502H     <= 1'b0;
            RingReqOutRequestorQ502H <= '0;
            RingReqOutOpcodeQ502H    <= '0;
            RingReqOutAddressQ502H   <= '0;
            RingReqOutDataQ502H      <= '0;
            lastLocalQnnnH           <= 1'b1;
            StarveCntQnnnH           <= '0;
            LocalStarveQnnnH         <= 1'b0;
        end else begin
            RingReqOutValidQ502H     <= nxtValid;
            RingReqOutRequestorQ502H <= nxtRequestor;
            RingReqOutOpcodeQ502H    <= nxtOpcode;
            RingReqOutAddressQ502H   <= nxtAddress;
            RingReqOutDataQ502H      <= nxtData;
            lastLocalQnnnH           <= lastLocalNxt;
            StarveCntQnnnH           <= starveCntNxt;
            LocalStarveQnnnH         <= (StarveCntQnnnH >= StarveThr);
        end
    end

endmodule

// File: tb/tb_rc_ring_out_arb.sv
// Directed bench for rc_ring_out_arb: one instance with a low starvation threshold,
// a second with a 2-bit counter to exercise saturation.
module tb_rc_ring_out_arb;
    import rc_ring_out_arb_pkg::*;

    logic        QClk = 1'b0;
    logic        RstQnnnH;

    logic        ringV, c2fV, f2cV;
    logic [9:0]  ringReq, c2fReq, f2cReq;
    t_opcode     ringOp, c2fOp, f2cOp;
    logic [31:0] ringAddr, c2fAddr, f2cAddr;
    logic [31:0] ringData, c2fData, f2cData;

    t_winner     selA, selB;
    logic        validA, validB;
    logic [9:0]  reqA, reqB;
    t_opcode     opA, opB;
    logic [31:0] addrA, addrB, dataA, dataB;
    logic        starveA, starveB;
    logic [7:0]  cntA;
    logic [1:0]  cntB;

    int total = 0;
    int bad   = 0;

    always #5 QClk = ~QClk;

    rc_ring_out_arb #(.STARVE_TH(4), .STARVE_W(8)) dutA (
        .QClk(QClk), .RstQnnnH(RstQnnnH),
        .RingPassValidQ501H(ringV), .RingPassRequestorQ501H(ringReq), .RingPassOpcodeQ501H(ringOp),
        .RingPassAddressQ501H(ringAddr), .RingPassDataQ501H(ringData),
        .C2F_ReqValidQ501H(c2fV), .C2F_ReqRequestorQ501H(c2fReq), .C2F_ReqOpcodeQ501H(c2fOp),
        .C2F_ReqAddressQ501H(c2fAddr), .C2F_ReqDataQ501H(c2fData),
        .F2C_RspValidQ501H(f2cV), .F2C_RspRequestorQ501H(f2cReq), .F2C_RspOpcodeQ501H(f2cOp),
        .F2C_RspAddressQ501H(f2cAddr), .F2C_RspDataQ501H(f2cData),
        .SelRingReqOutQ501H(selA),
        .RingReqOutValidQ502H(validA), .RingReqOutRequestorQ502H(reqA), .RingReqOutOpcodeQ502H(opA),
        .RingReqOutAddressQ502H(addrA), .RingReqOutDataQ502H(dataA),
        .LocalStarveQnnnH(starveA), .StarveCntQnnnH(cntA)
    );

    rc_ring_out_arb #(.STARVE_TH(3), .STARVE_W(2)) dutB (
        .QClk(QClk), .RstQnnnH(RstQnnnH),
        .RingPassValidQ501H(ringV), .RingPassRequestorQ501H(ringReq), .RingPassOpcodeQ501H(ringOp),
        .RingPassAddressQ501H(ringAddr), .RingPassDataQ501H(ringData),
        .C2F_ReqValidQ501H(c2fV), .C2F_ReqRequestorQ501H(c2fReq), .C2F_ReqOpcodeQ501H(c2fOp),
        .C2F_ReqAddressQ501H(c2fAddr), .C2F_ReqDataQ501H(c2fData),
        .F2C_RspValidQ501H(f2cV), .F2C_RspRequestorQ501H(f2cReq), .F2C_RspOpcodeQ501H(f2cOp),
        .F2C_RspAddressQ501H(f2cAddr), .F2C_RspDataQ501H(f2cData),
        .SelRingReqOutQ501H(selB),
        .RingReqOutValidQ502H(validB), .RingReqOutRequestorQ502H(reqB), .RingReqOutOpcodeQ502H(opB),
        .RingReqOutAddressQ502H(addrB), .RingReqOutDataQ502H(dataB),
        .LocalStarveQnnnH(starveB), .StarveCntQnnnH(cntB)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply valids on the falling edge so the rising edge sees stable inputs.
    task automatic drive(input logic r, input logic c, input logic f);
        @(negedge QClk);
        ringV = r;
        c2fV  = c;
        f2cV  = f;
        #1;
    endtask

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    initial begin
        RstQnnnH = 1'b0;
        ringV = 0; c2fV = 0; f2cV = 0;
        ringReq = 10'h155; ringOp = 4'h7; ringAddr = 32'h0A00_0010; ringData = 32'hDEAD_0001;
        c2fReq  = 10'h0C2; c2fOp  = 4'h2; c2fAddr  = 32'h1000_00C2; c2fData  = 32'h0000_0011;
        f2cReq  = 10'h0F2; f2cOp  = 4'h5; f2cAddr  = 32'h2000_00F2; f2cData  = 32'h0000_0022;

        #1;
        chk("rst_valid", 64'(validA), 64'(0));
        chk("rst_cnt",   64'(cntA),   64'(0));
        chk("rst_flag",  64'(starveA), 64'(0));
        repeat (2) @(posedge QClk);
        @(negedge QClk);
        RstQnnnH = 1'b1;

        // Round-robin: first contended cycle after reset goes to C2F.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1);
            chk("rr_sel", 64'(selA), (i % 2 == 0) ? 64'(C2F_REQUEST) : 64'(F2C_RESPONSE));
            tick();
            chk("rr_op",   64'(opA),   (i % 2 == 0) ? 64'(4'h2) : 64'(4'h5));
            chk("rr_addr", 64'(addrA), (i % 2 == 0) ? 64'h1000_00C2 : 64'h2000_00F2);
            chk("rr_valid", 64'(validA), 64'(1));
        end

        // Ring priority held for 10 cycles with locals waiting: starvation and saturation.
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1, 1);
            chk("ring_sel", 64'(selA), 64'(BYPASS));
            tick();
            if (i == 1) begin
                chk("ring_addr",  64'(addrA),  64'h0A00_0010);
                chk("ring_valid", 64'(validA), 64'(1));
                chk("ring_req",   64'(reqA),   64'(10'h155));
                chk("ring_data",  64'(dataA),  64'hDEAD_0001);
            end
            chk("starve_cnt",  64'(cntA),    64'(i));
            chk("starve_flag", 64'(starveA), (i >= 5) ? 64'(1) : 64'(0));
            chk("sat_cnt",     64'(cntB),    (i >= 3) ? 64'(3) : 64'(i));
            chk("sat_flag",    64'(starveB), (i >= 4) ? 64'(1) : 64'(0));
        end

        // Ring idle: C2F wins (last local grant was F2C), counter clears, flag lags one cycle.
        drive(0, 1, 1);
        chk("rel_sel", 64'(selA), 64'(C2F_REQUEST));
        tick();
        chk("rel_cnt",   64'(cntA),    64'(0));
        chk("rel_flag",  64'(starveA), 64'(1));
        chk("rel_flagB", 64'(starveB), 64'(1));
        chk("rel_data",  64'(dataA),   64'h0000_0011);

        drive(0, 0, 0);
        chk("idle_sel", 64'(selA), 64'(NO_WINNER));
        tick();
        chk("idle_valid", 64'(validA),  64'(0));
        chk("idle_addr",  64'(addrA),   64'(0));
        chk("idle_data",  64'(dataA),   64'(0));
        chk("idle_op",    64'(opA),     64'(0));
        chk("idle_req",   64'(reqA),    64'(0));
        chk("idle_cnt",   64'(cntA),    64'(0));
        chk("idle_flag",  64'(starveA), 64'(0));

        // Single local source wins alone.
        drive(0, 0, 1);
        chk("f2c_only_sel", 64'(selA), 64'(F2C_RESPONSE));
        tick();
        chk("f2c_only_data", 64'(dataA), 64'h0000_0022);

        // Leave last-granted = C2F, so only a reset makes C2F win the next contest.
        drive(0, 1, 0);
        chk("c2f_only_sel", 64'(selA), 64'(C2F_REQUEST));
        tick();
        drive(1, 1, 1);
        tick();
        chk("pre_rst_cnt",   64'(cntA),   64'(1));
        chk("pre_rst_valid", 64'(validA), 64'(1));

        @(negedge QClk);
        RstQnnnH = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(validA), 64'(0));
        chk("mid_rst_addr",  64'(addrA),  64'(0));
        chk("mid_rst_op",    64'(opA),    64'(0));
        chk("mid_rst_cnt",   64'(cntA),   64'(0));
        chk("mid_rst_sel",   64'(selA),   64'(BYPASS));
        @(negedge QClk);
        RstQnnnH = 1'b1;

        drive(0, 1, 1);
        chk("post_rst_sel", 64'(selA), 64'(C2F_REQUEST));
        tick();
        chk("post_rst_op", 64'(opA), 64'(4'h2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
